// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shifts data/parity/stop on device clock falls.
// Optional PS2_TX_ACK_CHECK_EN: a missing device ACK ends the frame with err instead of done.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 10_000,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic             ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;

  logic clk_s, data_s, fall, run, timeout, ack_bad;

  // clk_sync_q[2] is the previous synchronized sample, used for edge detect
  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign run     = (state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign timeout = run && (to_q == TO_LAST);
`ifdef PS2_TX_ACK_CHECK_EN
  assign ack_bad = (state_q == S_ACK) && fall && data_s;
`else
  assign ack_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      bit_q       <= '0;
      inh_q       <= '0;
      to_q        <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      inh_q       <= inh_d;
      to_q        <= to_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (tx_valid && ready_q) state_d = S_INHIBIT;
      S_INHIBIT:   if (inh_q == INH_LAST) state_d = S_REQ;
      S_REQ:       state_d = S_SHIFT;
      S_SHIFT:     if (timeout) state_d = S_IDLE;
                   else if (fall && bit_q == 4'd9) state_d = S_ACK;
      S_ACK:       if (timeout || ack_bad) state_d = S_IDLE;
                   else if (fall) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (timeout || (clk_s && data_s)) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_d   = frame_q;
    bit_d     = bit_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    inh_d     = (state_q == S_INHIBIT && state_d == S_INHIBIT) ? inh_q + INH_W'(1) : '0;
    // Timeout counter starts at 0 on the first cycle after the clock is released
    to_d      = (run && state_d != S_IDLE) ? to_q + TO_W'(1) : '0;
    if (state_q == S_IDLE && tx_valid && ready_q) begin
      frame_d = {1'b1, ~^tx_data, tx_data};
      bit_d   = '0;
    end
    if (state_q == S_SHIFT && !timeout && fall) begin
      data_oe_d = ~frame_q[bit_q];
      bit_d     = bit_q + 4'd1;
    end
    if (timeout || ack_bad) err_d = 1'b1;
    else if (state_q == S_WAIT_IDLE && state_d == S_IDLE) done_d = 1'b1;
    if (state_d == S_IDLE || state_d == S_INHIBIT) data_oe_d = 1'b0;
    if (state_d == S_REQ) data_oe_d = 1'b1;
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    ready_d  = (state_d == S_IDLE);
  end

  assign tx_ready    = ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on wired-AND pins, scoreboard queues for data bits and frame outcomes.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO  = 2000;
  localparam int HP  = 20;

  logic clk = 1'b0, rst;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, done, err, ps2_clk_oe, ps2_data_oe;
  logic dev_clk, dev_data, dev_en, ack_low, abort, dev_busy;
  int   falls, checks = 0, errors = 0, smp_n = 0;
  logic bq[$];
  logic [1:0] oq[$];
  event smp_ev;

  wire clk_pin  = dev_clk & ~ps2_clk_oe;
  wire data_pin = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .done(done), .err(err), .ps2_clk_i(clk_pin), .ps2_data_i(data_pin),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Device model: waits for request-to-send, then generates 11 clock pulses
  initial begin
    dev_clk = 1'b1; dev_data = 1'b1; dev_busy = 1'b0; falls = 0;
    forever begin
      @(negedge clk);
      if (dev_en && ps2_clk_oe) begin
        dev_busy = 1'b1; falls = 0;
        for (int n = 0; n < INH + 50 && ps2_clk_oe; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
          if (k == 11) begin dev_data = ~ack_low; repeat (4) @(negedge clk); end
          dev_clk = 1'b0; falls = k;
          repeat (HP) @(negedge clk);
          if (abort) break;
          dev_clk = 1'b1;
          if (k <= 10) -> smp_ev;
          repeat (HP) @(negedge clk);
        end
        dev_clk = 1'b1; dev_data = 1'b1;
        repeat (4) @(negedge clk);
        dev_busy = 1'b0;
      end
    end
  end

  // Bit monitor: data line the device samples on each rising clock
  always begin
    @(smp_ev);
    smp_n++;
    if (bq.size() == 0) begin
      checks++; errors++;
      $display("FAIL bit%0d: unexpected sample, data_oe=%0b", smp_n, ps2_data_oe);
    end else chk($sformatf("bit%0d", smp_n), 32'(ps2_data_oe), 32'(bq.pop_front()));
  end

  // Outcome monitor: done/err pulses
  always @(negedge clk) begin
    if (done || err) begin
      if (oq.size() == 0) begin
        checks++; errors++;
        $display("FAIL outcome: unexpected done=%0b err=%0b", done, err);
      end else chk("outcome{done,err}", 32'({done, err}), 32'(oq.pop_front()));
      chk("ready_at_end", 32'(tx_ready), 32'd1);
    end
  end

  // Inhibit/request monitor
  int hi = 0, dhi = 0;
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      hi++;
      if (ps2_data_oe) dhi++;
    end else if (hi != 0) begin
      chk("inhibit_plus_req_len", 32'(hi), 32'(INH + 1));
      chk("req_len", 32'(dhi), 32'd1);
      chk("data_oe_after_release", 32'(ps2_data_oe), 32'd1);
      hi = 0; dhi = 0;
    end
  end

  task automatic send(input logic [7:0] b, input logic par, input logic ack, input logic en);
    int n;
    dev_en = en; ack_low = ack;
    if (en) begin
      for (int k = 0; k < 8; k++) bq.push_back(~b[k]);
      bq.push_back(~par);
      bq.push_back(1'b0);
    end
    n = 0;
    while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((oq.size() != 0 || bq.size() != 0 || dev_busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s: frame incomplete, outcomes pending %0d bits pending %0d", nm, oq.size(), bq.size());
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_en = 1'b0; ack_low = 1'b1; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    oq.push_back(2'b10); send(8'hED, 1'b1, 1'b1, 1'b1); wait_done("frame_ED");
    oq.push_back(2'b10); send(8'h00, 1'b1, 1'b1, 1'b1); wait_done("frame_00");

    // Request during SHIFT must be ignored and must not disturb the frame
    oq.push_back(2'b10); send(8'h01, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (ps2_clk_oe && n < INH + 50) begin @(negedge clk); n++; end
    tx_data = 8'hAB; tx_valid = 1'b1;
    repeat (30) @(negedge clk);
    chk("ready_busy", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    wait_done("frame_01");

`ifdef PS2_TX_ACK_CHECK_EN
    oq.push_back(2'b01);
`else
    oq.push_back(2'b10);
`endif
    send(8'hFF, 1'b1, 1'b0, 1'b1); wait_done("frame_FF_noack");

    // Silent device: err exactly TO cycles after clock release
    oq.push_back(2'b01); send(8'h55, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (ps2_clk_oe && n < INH + 50) begin @(negedge clk); n++; end
    n = 0;
    while (!err && n < TO + 100) begin @(negedge clk); n++; end
    chk("timeout_latency", 32'(n), 32'(TO));
    chk("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("timeout_ready", 32'(tx_ready), 32'd1);
    wait_done("frame_timeout");

    // Asynchronous reset mid-frame at fall 5
    send(8'hED, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (falls != 5 && n < 3000) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("pre_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    #1 rst = 1'b1; abort = 1'b1;
    #1;
    chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("midrst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (dev_busy && n < 500) begin @(negedge clk); n++; end
    bq.delete();
    abort = 1'b0;
    repeat (50) @(negedge clk);
    chk("postrst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("postrst_ready", 32'(tx_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
